serial_subtractor_8_bit: RTL and testbench
==========================================

// Module: serial_subtractor_8_bit
// PURPOSE
//  Bit-serial WIDTH-bit subtractor with borrow: d = a - b - bin, bout = borrow out.
//  Inverse companion of the parallel ripple full adder; one full-subtractor cell is reused over WIDTH clocks.
//  Used in the arithmetic lab datapath wherever a small, area-cheap multi-cycle subtract is acceptable.
//  start/busy/done handshake toward the controlling FSM or testbench.
// PARAMETERS
//  WIDTH   8   operand and result width in bits; must be >= 2
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only in IDLE or DONE
//  a       in   WIDTH  minuend, captured on the accepting edge
//  b       in   WIDTH  subtrahend, captured on the accepting edge
//  bin     in   1      borrow in, captured on the accepting edge
//  busy    out  1      high while an operation is in progress
//  done    out  1      one-cycle pulse: d/bout just updated
//  d       out  WIDTH  difference, held until the next result
//  bout    out  1      borrow out (1 => a < b + bin, unsigned), held like d
// BEHAVIOUR
//  - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset (async assert, sync release): state=IDLE; busy=0, done=0, d=0, bout=0.
//    Internal shift registers, borrow flop and bit counter are also cleared.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE: start=1 at an edge -> latch a, b, bin into internal regs; cnt=0; go RUN.
//  - RUN, one bit per cycle, LSB first; x = a_sh[0], y = b_sh[0], c = borrow flop:
//    diff = x ^ y ^ c
//    borrow_next = (~x & y) | (~(x ^ y) & c)
//    diff shifts into the result reg from the MSB end; a_sh and b_sh shift right.
//    cnt increments; after the WIDTH-th RUN edge go DONE.
//    On that same edge, load d with the full result and bout with the final borrow.
//  - Latency: done is high in the cycle after the WIDTH-th edge following the accepting edge.
//    Accept-to-done is exactly WIDTH cycles.
//  - busy=1 in RUN only. start is ignored while busy; no queuing, no error flag.
//  - DONE lasts exactly one cycle with done=1, then:
//    start=1 in DONE -> accept new operands and go RUN (back-to-back, no IDLE bubble);
//    otherwise go IDLE.
//  - d/bout change only on the completing edge and on reset.
//    They stay stable through the next operation until it completes.
//  - Arithmetic is unsigned modulo 2^WIDTH; wrap-around is reported via bout only.
//    No signed overflow output.
//  - Operand inputs a, b, bin may change freely after the accepting edge.
//  - rst_n low mid-RUN: aborts immediately; outputs return to reset values; no done pulse.
// TESTING
//  1. a=204,b=3,bin=1 -> after 8 cycles: d=200, bout=0, done pulses once.
//  2. a=69,b=30,bin=0 -> d=39, bout=0; a=43,b=32,bin=1 -> d=10, bout=0 (inverse of the adder cases).
//  3. a=0,b=0,bin=1 -> d=255, bout=1; a=3,b=200,bin=0 -> d=59, bout=1 (wrap-around).
//  4. start held high during RUN with new operands -> ignored; first result intact.
//     Start in the DONE cycle -> next op begins, its done comes 8 cycles later.
//  5. rst_n low at RUN cycle 4 -> busy=0, d=0, bout=0 at once, no done pulse.
//     After release, a=255,b=255,bin=0 -> d=0, bout=0.
//  6. Self-check: random a,b,bin (1000 ops) vs {bout,d} = {1'b0,a} - b - bin in 9 bits.
//     Also check busy is high exactly 8 cycles per op.

Source files
------------

// File: rtl/serial_subtractor_8_bit_if.sv
// Handshake and operand bus for the bit-serial subtractor.
// The controller drives start/a/b/bin through the master modport; the
// subtractor returns busy/done/d/bout through the slave modport.
interface serial_subtractor_8_bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor_8_bit.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - bin, bout = final borrow.
// A single full-subtractor cell is reused over WIDTH clocks, LSB first.
// Handshake: start accepted in IDLE or DONE, busy high while running,
// done pulses for one cycle when d/bout have just been updated.
module serial_subtractor_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_8_bit_if.slave io_sub
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_x;
  logic             w_y;
  logic             w_diff;
  logic             w_borrow_next;
  logic             w_accept;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs of the operand shifters.
  assign w_x           = r_a_sh[0];
  assign w_y           = r_b_sh[0];
  assign w_diff        = w_x ^ w_y ^ r_borrow;
  assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

  // Difference bits enter from the MSB end so the LSB lands at bit 0
  // after WIDTH shifts.
  assign w_res_next = {w_diff, r_res_sh[WIDTH-1:1]};

  // start is only looked at when no operation is in flight; DONE accepts
  // too, which gives back-to-back operation without an IDLE bubble.
  assign w_accept   = io_sub.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

  // Sequencing FSM plus the serial datapath it steers.
  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values of each other; a blocking '=' would let the shifters see
  // the already-updated borrow flop within the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a_sh   <= io_sub.a;
            r_b_sh   <= io_sub.b;
            r_borrow <= io_sub.bin;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_state  <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_borrow <= w_borrow_next;
          r_res_sh <= w_res_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last_bit) begin
            // Results are published only here, so d/bout stay stable
            // throughout the following operation.
            r_d     <= w_res_next;
            r_bout  <= w_borrow_next;
            r_state <= ST_DONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decode directly from the state register.
  assign io_sub.busy = (r_state == ST_RUN);
  assign io_sub.done = (r_state == ST_DONE);
  assign io_sub.d    = r_d;
  assign io_sub.bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_8_bit.sv
// Self-checking bench for serial_subtractor_8_bit: directed cases plus
// randomized operations compared against plain 9-bit arithmetic.
module tb_serial_subtractor_8_bit;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 20;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] last_d;
  logic             last_bout;

  serial_subtractor_8_bit_if #(.WIDTH(WIDTH)) sub_if ();

  serial_subtractor_8_bit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_sub (sub_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: unsigned subtract in WIDTH+1 bits; top bit is the borrow.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             bin);
    return {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
  endfunction

  // Called at the negedge right after the accepting edge. Walks negedges
  // until done (bounded), counting busy cycles and watching d/bout hold.
  task automatic wait_done(output int busy_cycles, output bit held_ok);
    busy_cycles = 0;
    held_ok     = 1'b1;
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (sub_if.done) break;
      if (sub_if.busy) busy_cycles++;
      if (sub_if.d !== last_d || sub_if.bout !== last_bout) held_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH:0] exp,
                              input int busy_cycles, input bit held_ok);
    check($sformatf("%s done", tag), sub_if.done, 1);
    check($sformatf("%s busy_cycles", tag), busy_cycles, WIDTH);
    check($sformatf("%s d", tag), sub_if.d, exp[WIDTH-1:0]);
    check($sformatf("%s bout", tag), sub_if.bout, exp[WIDTH]);
    check($sformatf("%s held", tag), held_ok, 1);
    last_d    = exp[WIDTH-1:0];
    last_bout = exp[WIDTH];
  endtask

  // Issue one operation from a negedge where the DUT is in IDLE or DONE;
  // returns at the negedge where done is observed.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input string tag);
    int busy_cycles;
    bit held_ok;
    logic [WIDTH:0] exp;
    exp = ref_sub(a, b, bin);
    sub_if.start = 1'b1;
    sub_if.a     = a;
    sub_if.b     = b;
    sub_if.bin   = bin;
    @(posedge clk);
    @(negedge clk);
    sub_if.start = 1'b0;
    sub_if.a     = WIDTH'($urandom);
    sub_if.b     = WIDTH'($urandom);
    sub_if.bin   = 1'($urandom);
    wait_done(busy_cycles, held_ok);
    check_result(tag, exp, busy_cycles, held_ok);
  endtask

  initial begin
    int  busy_cycles;
    bit  held_ok;
    bit  saw_done;
    logic [WIDTH-1:0] ra, rb;
    logic             rbin;

    n_checks  = 0;
    n_fail    = 0;
    last_d    = '0;
    last_bout = 1'b0;

    rst_n        = 1'b0;
    sub_if.start = 1'b0;
    sub_if.a     = '0;
    sub_if.b     = '0;
    sub_if.bin   = 1'b0;
    repeat (3) @(negedge clk);

    check("reset busy", sub_if.busy, 0);
    check("reset done", sub_if.done, 0);
    check("reset d", sub_if.d, 0);
    check("reset bout", sub_if.bout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle done", sub_if.done, 0);

    // Basic and adder-inverse cases.
    run_op(8'd204, 8'd3, 1'b1, "t1");
    @(negedge clk);
    check("t1 done one cycle", sub_if.done, 0);
    run_op(8'd69, 8'd30, 1'b0, "t2a");
    run_op(8'd43, 8'd32, 1'b1, "t2b");

    // Wrap-around.
    @(negedge clk);
    run_op(8'd0, 8'd0, 1'b1, "t3a");
    run_op(8'd3, 8'd200, 1'b0, "t3b");
    @(negedge clk);

    // start held through RUN with new operands: ignored until DONE, where
    // it is accepted back-to-back.
    sub_if.start = 1'b1;
    sub_if.a     = 8'd100;
    sub_if.b     = 8'd50;
    sub_if.bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sub_if.a   = 8'd7;
    sub_if.b   = 8'd9;
    sub_if.bin = 1'b1;
    wait_done(busy_cycles, held_ok);
    check_result("t4 first", ref_sub(8'd100, 8'd50, 1'b0), busy_cycles, held_ok);
    @(posedge clk);
    @(negedge clk);
    sub_if.start = 1'b0;
    check("t4 accept in done busy", sub_if.busy, 1);
    wait_done(busy_cycles, held_ok);
    check_result("t4 second", ref_sub(8'd7, 8'd9, 1'b1), busy_cycles, held_ok);
    @(negedge clk);

    // Reset mid-RUN after four bit edges.
    sub_if.start = 1'b1;
    sub_if.a     = 8'd150;
    sub_if.b     = 8'd20;
    sub_if.bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sub_if.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 abort busy", sub_if.busy, 0);
    check("t5 abort done", sub_if.done, 0);
    check("t5 abort d", sub_if.d, 0);
    check("t5 abort bout", sub_if.bout, 0);
    last_d    = '0;
    last_bout = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sub_if.done || sub_if.busy) saw_done = 1'b1;
    end
    check("t5 no done after abort", saw_done, 0);
    run_op(8'd255, 8'd255, 1'b0, "t5 post");

    // Randomized operations, mixing back-to-back starts and idle gaps.
    for (int n = 0; n < 1000; n++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rbin = 1'($urandom);
      if (n % 50 == 0) rb = ra;
      if (n % 50 == 1) begin ra = '0; rb = '1; end
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        check($sformatf("rnd%0d gap done", n), sub_if.done, 0);
      end
      run_op(ra, rb, rbin, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
